baser_rx_lock_descrambler: RTL

Receive-side 64b/66b front end: takes raw 66-bit blocks from the SERDES gearbox, acquires and monitors block lock on the 2-bit sync header, requests bit slips while unlocked, and descrambles the payload with the self-synchronising x^58+x^39+1 polynomial. It is the receive counterpart of the 64b/66b transmit path and feeds the block decoder.

---
 rtl/baser_pkg.sv | 24 ++
 rtl/baser_descrambler.sv | 44 ++++
 rtl/baser_rx_lock_descrambler.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/baser_pkg.sv
// Shared 64b/66b receive definitions: sync headers, descrambler taps, lock FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package baser_pkg;

  // Sync header encodings; 2'b00 and 2'b11 are never legal on the line.
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // Scrambler polynomial x^58 + x^39 + 1.
  localparam int SCR_TAP_A = 39;
  localparam int SCR_TAP_B = 58;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SLIP     = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  function automatic logic hdr_is_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/baser_descrambler.sv
// Self-synchronising x^58+x^39+1 descrambler: history register plus parallel XOR network.
// Latency: combinational data path; history advances on each enabled block.
// Backpressure: none; blocks with valid low leave the history untouched.
//
// Ports: clk, rst_n      clock and async active-low reset
//        valid           history update enable for the current block
//        in_data         scrambled payload, bit 0 received first
//        out_data        descrambled payload (combinational)
module baser_descrambler
  import baser_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data
);

  // hist[57] is the most recently received scrambled bit.
  logic [SCR_TAP_B-1:0]            hist;
  logic [DATA_WIDTH+SCR_TAP_B-1:0] ext;

  assign ext = {in_data, hist};

  // Input bit i sits at ext[i+58]; the bits 39 and 58 positions earlier
  // are ext[i+19] and ext[i].
  always_comb begin
    out_data = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      out_data[i] = in_data[i] ^ ext[i + SCR_TAP_B - SCR_TAP_A] ^ ext[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
    end else if (valid) begin
      hist <= in_data[DATA_WIDTH-1 -: SCR_TAP_B];
    end
  end

endmodule

// File: rtl/baser_rx_lock_descrambler.sv
// 64b/66b receive front end: sync-header block lock, bitslip requests, payload descrambling.
// Latency: 1 cycle input to all outputs (all outputs registered).
// Backpressure: none; serdes_rx_valid low freezes every counter, the history and the outputs.
//
// Ports: clk, rst_n                      clock, async active-low reset
//        serdes_rx_data/hdr/valid        raw block from the gearbox
//        rx_data/hdr/valid               descrambled block, valid only while locked
//        rx_block_lock                   lock status
//        serdes_rx_bitslip               one-cycle slip request to the gearbox
//        rx_hdr_err_count                saturating count of bad headers seen while locked
module baser_rx_lock_descrambler
  import baser_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int HDR_WIDTH   = 2,
  parameter int LOCK_COUNT  = 64,
  parameter int WINDOW      = 64,
  parameter int INVALID_MAX = 16,
  parameter int SLIP_WAIT   = 8,
  parameter int ERR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] serdes_rx_data,
  input  logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
  input  logic                  serdes_rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic [HDR_WIDTH-1:0]  rx_hdr,
  output logic                  rx_valid,
  output logic                  rx_block_lock,
  output logic                  serdes_rx_bitslip,
  output logic [ERR_WIDTH-1:0]  rx_hdr_err_count
);

  localparam int SH_W   = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W  = $clog2(WINDOW + 1);
  localparam int INV_W  = $clog2(INVALID_MAX + 1);
  localparam int SLIP_W = $clog2(SLIP_WAIT + 1);

  lock_state_t          state_q, state_d;
  logic [SH_W-1:0]      sh_q, sh_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [INV_W-1:0]     inv_q, inv_d;
  logic [SLIP_W-1:0]    slip_q, slip_d;
  logic [ERR_WIDTH-1:0] err_q, err_d;
  logic                 slip_pulse;
  logic                 hdr_bad;
  logic [SH_W-1:0]      sh_inc;
  logic [WIN_W-1:0]     win_inc;
  logic [INV_W-1:0]     inv_inc;
  logic [SLIP_W-1:0]    slip_inc;
  logic [DATA_WIDTH-1:0] descr_data;

  baser_descrambler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_descrambler (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (serdes_rx_valid),
    .in_data  (serdes_rx_data),
    .out_data (descr_data)
  );

  assign hdr_bad  = !hdr_is_valid(serdes_rx_hdr);
  assign sh_inc   = sh_q + SH_W'(1);
  assign win_inc  = win_q + WIN_W'(1);
  assign inv_inc  = inv_q + INV_W'(hdr_bad);
  assign slip_inc = slip_q + SLIP_W'(1);

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    win_d      = win_q;
    inv_d      = inv_q;
    slip_d     = slip_q;
    err_d      = err_q;
    slip_pulse = 1'b0;

    if (serdes_rx_valid) begin
      case (state_q)
        UNLOCKED: begin
          if (hdr_bad) begin
            slip_pulse = 1'b1;
            sh_d       = '0;
            slip_d     = '0;
            state_d    = SLIP;
          end else if (sh_inc == SH_W'(LOCK_COUNT)) begin
            sh_d    = '0;
            win_d   = '0;
            inv_d   = '0;
            state_d = LOCKED;
          end else begin
            sh_d = sh_inc;
          end
        end

        // Headers are ignored here while the gearbox settles after the slip.
        SLIP: begin
          if (slip_inc == SLIP_W'(SLIP_WAIT)) begin
            slip_d  = '0;
            sh_d    = '0;
            state_d = UNLOCKED;
          end else begin
            slip_d = slip_inc;
          end
        end

        LOCKED: begin
          if (hdr_bad && (err_q != {ERR_WIDTH{1'b1}})) begin
            err_d = err_q + ERR_WIDTH'(1);
          end
          // The invalid-limit test comes first so a limit-reaching header on
          // the window's last block still drops lock.
          if (inv_inc == INV_W'(INVALID_MAX)) begin
            slip_pulse = 1'b1;
            win_d      = '0;
            inv_d      = '0;
            slip_d     = '0;
            sh_d       = '0;
            state_d    = SLIP;
          end else if (win_inc == WIN_W'(WINDOW)) begin
            win_d = '0;
            inv_d = '0;
          end else begin
            win_d = win_inc;
            inv_d = inv_inc;
          end
        end

        default: begin
          state_d = UNLOCKED;
          sh_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNLOCKED;
      sh_q    <= '0;
      win_q   <= '0;
      inv_q   <= '0;
      slip_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      win_q   <= win_d;
      inv_q   <= inv_d;
      slip_q  <= slip_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data           <= '0;
      rx_hdr            <= '0;
      rx_valid          <= 1'b0;
      rx_block_lock     <= 1'b0;
      serdes_rx_bitslip <= 1'b0;
    end else begin
      if (serdes_rx_valid) begin
        rx_data <= descr_data;
        rx_hdr  <= serdes_rx_hdr;
      end
      // Lock as it stands after this block: the locking block is emitted,
      // the lock-dropping block is not.
      rx_valid          <= serdes_rx_valid && (state_d == LOCKED);
      rx_block_lock     <= (state_d == LOCKED);
      serdes_rx_bitslip <= slip_pulse;
    end
  end

  assign rx_hdr_err_count = err_q;

endmodule
